// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline stall/flush sequencer; optional perf counters via PERF_CNT_EN
module pipeline_hazard_ctrl #(
  parameter int RF_ADDR_W   = 5,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [RF_ADDR_W-1:0] id_rs1,
  input  logic [RF_ADDR_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [RF_ADDR_W-1:0] ex_rd,
  input  logic                 ex_mem_read,
  input  logic                 ex_redirect,
  input  logic                 mem_req,
  input  logic                 mem_ready,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 id_ex_en,
  output logic                 ex_mem_en,
  output logic                 mem_wb_en,
  output logic                 if_id_flush,
  output logic                 id_ex_flush,
  output logic                 mem_timeout_err,
  output logic [1:0]           ctrl_state
`ifdef PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]     stall_cycles,
  output logic [CNT_W-1:0]     flush_events
`endif
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // Wait counter only has to reach MEM_TIMEOUT; it never counts past it.
  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);

  if (RF_ADDR_W < 1 || CNT_W < 1) begin : g_bad_params
    $error("pipeline_hazard_ctrl: RF_ADDR_W and CNT_W must be at least 1");
  end

  state_t              state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                err_q, err_d;
  logic                load_use;
  logic                run_rules;

  // A dependent load in EX must hold the consumer in ID for one cycle; x0 never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));

  // State, wait counter and sticky timeout flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
    end
  end

  // Next state, and whether this cycle's enables follow the normal hazard rules.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    err_d      = err_q;
    run_rules  = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_ONE;
        end else begin
          run_rules  = 1'b1;
          wait_cnt_d = '0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          run_rules  = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if ((MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_V)) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_ONE;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Enables and flushes: frozen pipe unless the hazard rules apply; redirect outranks load-use.
  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    id_ex_en    = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (reset_n && run_rules) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end
  end

  assign mem_timeout_err = err_q;
  assign ctrl_state      = state_q;

`ifdef PERF_CNT_EN
  // Stall and flush event counters; both wrap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT))) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
      if (id_ex_flush) begin
        flush_events <= flush_events + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

  localparam int TO = 4;
  localparam int CW = 16;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, ex_mem_read = 1'b0;
  logic       ex_redirect = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, mem_timeout_err;
  logic [1:0] ctrl_state;
`ifdef PERF_CNT_EN
  logic [CW-1:0] stall_cycles, flush_events;
`endif

  pipeline_hazard_ctrl #(.RF_ADDR_W(5), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clock(clock), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_timeout_err(mem_timeout_err), .ctrl_state(ctrl_state)
`ifdef PERF_CNT_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  always #5 clock = ~clock;

  // expected word: {pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, err, state[1:0]}
  typedef struct {
    logic [9:0] word;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  // reference model: memory-wait bookkeeping as plain flags and a cycle tally
  bit waiting = 0, errored = 0;
  int waited = 0;
  bit prev_rst = 0, prev_req = 0, prev_rdy = 0;
  int m_stalls = 0, m_flushes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endtask

  task automatic model_step();
    if (!prev_rst) begin
      waiting = 0; errored = 0; waited = 0;
    end else if (errored) begin
      errored = 1;
    end else if (waiting) begin
      if (prev_rdy) begin
        waiting = 0; waited = 0;
      end else if (waited == TO) begin
        waiting = 0; errored = 1;
      end else begin
        waited++;
      end
    end else if (prev_req && !prev_rdy) begin
      waiting = 1; waited = 1;
    end
  endtask

  task automatic cyc(input string tag, input bit rst, input int rs1, input int rs2,
                     input bit u1, input bit u2, input int rd, input bit ld,
                     input bit redir, input bit req, input bit rdy);
    bit lu, frozen;
    bit [4:0] en;
    bit [1:0] fl;
    int st;
    exp_t e;
    @(posedge clock);
    #1;
    model_step();
    reset_n = rst; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2); id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = 5'(rd); ex_mem_read = ld; ex_redirect = redir; mem_req = req; mem_ready = rdy;
    if (!rst) begin
      waiting = 0; errored = 0; waited = 0; m_stalls = 0; m_flushes = 0;
    end
    lu = ld && rd != 0 && ((u1 && rd == rs1) || (u2 && rd == rs2));
    frozen = !rst || errored || (waiting && !rdy) || (!waiting && req && !rdy);
    en = 5'b00000; fl = 2'b00;
    if (!frozen) begin
      if (redir) begin en = 5'b11111; fl = 2'b11; end
      else if (lu) begin en = 5'b00111; fl = 2'b01; end
      else en = 5'b11111;
    end
    st = errored ? 2 : (waiting ? 1 : 0);
    if (rst && !errored && !en[4]) m_stalls++;
    if (rst && fl[0]) m_flushes++;
    e.word = {en, fl, errored, 2'(st)};
    e.tag = tag;
    exp_q.push_back(e);
    prev_rst = rst; prev_req = req; prev_rdy = rdy;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cyc(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  // monitor: compares every presented cycle against the oldest expectation
  initial begin
    exp_t e;
    logic [9:0] got;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, mem_timeout_err, ctrl_state};
        check(e.tag, 32'(got), 32'(e.word));
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) cyc("reset", 0, 5, 5, 1, 1, 5, 1, 1, 1, 0);
    idle("idle", 2);

    for (int i = 0; i < 600; i++) begin
      cyc("random", ($urandom_range(99) >= 2),
          $urandom_range(3), $urandom_range(3), $urandom_range(1), $urandom_range(1),
          $urandom_range(3), ($urandom_range(99) < 40), ($urandom_range(99) < 15),
          ($urandom_range(99) < 30), ($urandom_range(99) < 45));
    end

    cyc("reset2", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle("idle", 1);
    cyc("load_use", 1, 5, 0, 1, 0, 5, 1, 0, 0, 1);
    idle("after_lu", 1);
    cyc("load_x0", 1, 0, 0, 1, 0, 0, 1, 0, 0, 1);
    cyc("rs2_unused", 1, 1, 5, 1, 0, 5, 1, 0, 0, 1);
    cyc("redir_lu", 1, 5, 0, 1, 0, 5, 1, 1, 0, 1);
    cyc("lu_rs2", 1, 2, 9, 1, 1, 9, 1, 0, 0, 1);
    cyc("mem_start", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mem_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mem_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mem_release", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle("after_mem", 1);
    cyc("release_lu", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("release_lu", 1, 3, 0, 1, 0, 3, 1, 0, 1, 1);
    for (int i = 0; i < 8; i++) cyc("timeout", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc("error_ready", 1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    cyc("err_reset", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle("post_reset", 1);
    cyc("perf_lu", 1, 5, 0, 1, 0, 5, 1, 0, 0, 1);
    cyc("perf_lu", 1, 6, 0, 1, 0, 6, 1, 0, 0, 1);
    cyc("perf_redir", 1, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    idle("tail", 1);

    @(negedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
`ifdef PERF_CNT_EN
    check("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
    check("flush_events", 32'(flush_events), 32'(m_flushes));
    reset_n = 1'b0;
    #1;
    check("stall_async_rst", 32'(stall_cycles), 32'd0);
    check("flush_async_rst", 32'(flush_events), 32'd0);
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
